mem_if_unit: RTL and testbench
==============================

Name: mem_if_unit

Overview:
- Clocked, parametrised successor to the combinational MAR/MDR pair of the RSC datapath.
- Holds the memory address register (MAR) and memory data register (MDR), and sequences read/write transactions to an external memory over a req/ready handshake.
- Adds bounded wait states with a timeout error, and an optional MAR auto-increment.
- Sits between the internal data bus and the memory port; the control unit issues load, drive and start commands.

Parameters:
- DATA_W, 16, bus/MDR/memory data width.
- ADDR_W, 16, MAR/memory address width; MAR loads bus_in[ADDR_W-1:0].
- TIMEOUT, 15, maximum cycles waiting for mem_ready before error; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- bus_in  in  DATA_W  data from internal bus.
- bus_out  out  DATA_W  MDR value to bus; 0 when bus_out_en=0.
- bus_out_en  out  1  bus driver enable.
- ld_mar  in  1  load MAR from bus_in.
- ld_mdr  in  1  load MDR from bus_in.
- drv_mdr  in  1  request MDR onto bus.
- rd_start  in  1  start memory read.
- wr_start  in  1  start memory write.
- mem_addr  out  ADDR_W  MAR value, continuously.
- mem_wdata  out  DATA_W  MDR value, continuously.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_ready  in  1  memory completes the access.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, access finished.
- err  out  1  one-cycle pulse, timeout or command conflict.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: mar=0, mdr=0, state=IDLE, wait counter=0. All outputs 0: mem_rd, mem_wr, busy, done, err, bus_out_en, bus_out=0.
- States: IDLE, RD_ACC, WR_ACC, FIN.
- Decoded outputs:
  - mem_rd=1 exactly in RD_ACC; mem_wr=1 exactly in WR_ACC.
  - busy=1 in RD_ACC, WR_ACC and FIN.
  - done is registered: high for the FIN cycle only.
- Loads in IDLE:
  - ld_mar loads MAR; ld_mdr loads MDR, taking effect on that clock edge.
  - ld_mar and ld_mdr together: both load the same bus_in value.
- Starts in IDLE:
  - rd_start -> RD_ACC next cycle; wr_start -> WR_ACC next cycle.
  - rd_start and wr_start together: no transaction, err pulses next cycle, state stays IDLE.
  - A load together with a start: the load is applied at the same edge, so the access uses the new value.
- RD_ACC: on the edge where mem_ready=1, mdr<=mem_rdata and state->FIN.
- WR_ACC: on the edge where mem_ready=1, state->FIN; mem_wdata holds MDR throughout.
- Wait counter:
  - Cleared on entry to RD_ACC/WR_ACC; increments each cycle mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0: state->IDLE, err pulses for 1 cycle, done is not asserted, MDR is unchanged.
  - If mem_ready=1 in the same cycle the counter reaches TIMEOUT, ready wins.
- FIN: done=1, then IDLE next cycle.
- Minimum latency: start at edge 0, ready on the first access cycle, done high in cycle 2, new command accepted at edge 3.
- While busy: ld_mar, ld_mdr, rd_start and wr_start are ignored without error, and bus_out_en=0 even if drv_mdr=1 (no MDR read while it may be written).
- In IDLE: bus_out_en=drv_mdr and bus_out=mdr, combinationally.
- Reset mid-access: returns to IDLE at that edge; mem_rd/mem_wr low from the next cycle; done and err are not pulsed; registers are zeroed.
- mem_ready outside RD_ACC/WR_ACC is ignored.

Optional Feature:
- Macro: MAR_AUTOINC_EN.
- Defined: on each successful completion (transition into FIN), mar<=mar+1 modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000. A timeout does not increment.
- Undefined: MAR changes only via ld_mar or reset.

Decomposition:
- Shared package mem_if_pkg:
  - state enum (IDLE, RD_ACC, WR_ACC, FIN);
  - function computing the counter width, $clog2(TIMEOUT+1).
- One sub-module: mem_if_wait_ctr, the clear/increment/terminal-count counter producing a timeout flag.

Test Plan:
- Reset, then ld_mar with bus_in=0x1234 and ld_mdr with bus_in=0xBEEF, then drv_mdr -> mem_addr=0x1234, bus_out=0xBEEF, bus_out_en=1.
- rd_start, mem_ready held low 3 cycles then high with mem_rdata=0x5A5A -> mem_rd high 4 cycles, MDR=0x5A5A, done one cycle later, busy low after.
- wr_start with MDR=0x00FF and mem_ready never high -> mem_wr high TIMEOUT cycles, err pulse, no done, MDR still 0x00FF.
- rd_start and wr_start in the same cycle -> err pulse, mem_rd=mem_wr=0, busy stays 0.
- During RD_ACC: ld_mar with 0x9999 and drv_mdr=1 -> MAR unchanged, bus_out_en=0. Then rst mid-access -> IDLE, mem_rd low the next cycle, all registers 0.
- With MAR_AUTOINC_EN: MAR=0xFFFF, write completes -> MAR=0x0000. A timed-out access leaves MAR unchanged.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the memory interface unit (MAR/MDR + req/ready sequencer).
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ACC = 2'd1,
    WR_ACC = 2'd2,
    FIN    = 2'd3
  } state_t;

  // Width of the wait counter: just wide enough to hold TIMEOUT.
  function automatic int ctr_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_if_wait_ctr.sv
// Wait-state counter: clears, counts cycles without mem_ready, flags the TIMEOUT-th idle cycle.
module mem_if_wait_ctr
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int W = ctr_width(TIMEOUT);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires in the cycle whose increment would bring the count to TIMEOUT.
  assign expire = inc && !clr && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_if_unit.sv
// MAR/MDR register pair with a req/ready memory sequencer, bounded wait states and timeout error.
// Optional feature: define MAR_AUTOINC_EN to post-increment MAR on every completed access.
module mem_if_unit
  import mem_if_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_out_en,
  input  logic              ld_mar,
  input  logic              ld_mdr,
  input  logic              drv_mdr,
  input  logic              rd_start,
  input  logic              wr_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              err_q, err_n;
  logic              in_access;
  logic              complete;
  logic              expire;

  assign in_access = (state == RD_ACC) || (state == WR_ACC);
  assign complete  = in_access && mem_ready;

  mem_if_wait_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (!in_access),
    .inc   (in_access && !mem_ready),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= err_n;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_start && wr_start) begin
          err_n = 1'b1;
        end else if (rd_start) begin
          state_n = RD_ACC;
        end else if (wr_start) begin
          state_n = WR_ACC;
        end
      end
      RD_ACC, WR_ACC: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (mem_ready) begin
          state_n = FIN;
        end else if (expire) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (state == IDLE) begin
        if (ld_mar) mar <= bus_in[ADDR_W-1:0];
        if (ld_mdr) mdr <= bus_in;
      end
      if ((state == RD_ACC) && mem_ready) begin
        mdr <= mem_rdata;
      end
`ifdef MAR_AUTOINC_EN
      if (complete) begin
        mar <= mar + 1'b1;
      end
`else
      if (complete && 1'b0) begin
        mar <= mar;
      end
`endif
    end
  end

  // The MDR is only driven onto the bus while no access can be writing it.
  assign bus_out_en = (state == IDLE) && drv_mdr;
  assign bus_out    = bus_out_en ? mdr : '0;
  assign mem_addr   = mar;
  assign mem_wdata  = mdr;
  assign mem_rd     = (state == RD_ACC);
  assign mem_wr     = (state == WR_ACC);
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);
  assign err        = err_q;

endmodule

// File: tb/tb_mem_if_unit.sv
// Directed self-checking bench for mem_if_unit; expectations follow MAR_AUTOINC_EN when defined.
module tb_mem_if_unit;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_out_en;
  logic              ld_mar, ld_mdr, drv_mdr, rd_start, wr_start;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rd, mem_wr, mem_ready;
  logic              busy, done, err;

  int errors = 0;
  int checks = 0;
  logic [ADDR_W-1:0] exp_mar;

  mem_if_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_in    (bus_in),
    .bus_out   (bus_out),
    .bus_out_en(bus_out_en),
    .ld_mar    (ld_mar),
    .ld_mdr    (ld_mdr),
    .drv_mdr   (drv_mdr),
    .rd_start  (rd_start),
    .wr_start  (wr_start),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic inc_mar_on_success();
`ifdef MAR_AUTOINC_EN
    exp_mar = exp_mar + 1'b1;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; bus_in = '0; ld_mar = 0; ld_mdr = 0; drv_mdr = 0;
    rd_start = 0; wr_start = 0; mem_rdata = '0; mem_ready = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_addr",   mem_addr,   0);
    check("rst_wdata",  mem_wdata,  0);
    check("rst_busy",   busy,       0);
    check("rst_done",   done,       0);
    check("rst_err",    err,        0);
    check("rst_rd",     mem_rd,     0);
    check("rst_wr",     mem_wr,     0);
    check("rst_bus_en", bus_out_en, 0);
    check("rst_bus",    bus_out,    0);

    // Loads and bus drive
    bus_in = 16'h1234; ld_mar = 1; tick(); ld_mar = 0;
    bus_in = 16'hBEEF; ld_mdr = 1; tick(); ld_mdr = 0;
    drv_mdr = 1; #1;
    check("ld_addr",   mem_addr,   16'h1234);
    check("ld_bus",    bus_out,    16'hBEEF);
    check("ld_bus_en", bus_out_en, 1);
    check("ld_wdata",  mem_wdata,  16'hBEEF);
    drv_mdr = 0;
    exp_mar = 16'h1234;

    // Read with three wait states; loads and drive ignored while busy
    rd_start = 1; tick(); rd_start = 0;
    for (int i = 0; i < 4; i++) begin
      check("rd_mem_rd", mem_rd, 1);
      check("rd_busy", busy, 1);
      if (i == 1) begin
        ld_mar = 1; bus_in = 16'h9999; drv_mdr = 1; #1;
        check("rd_bus_en_busy", bus_out_en, 0);
        check("rd_bus_busy", bus_out, 0);
      end else begin
        ld_mar = 0; drv_mdr = 0;
      end
      if (i == 3) begin mem_ready = 1; mem_rdata = 16'h5A5A; end
      tick();
    end
    mem_ready = 0; ld_mar = 0; drv_mdr = 0;
    inc_mar_on_success();
    check("rd_done",   done,      1);
    check("rd_mem_rd_off", mem_rd, 0);
    check("rd_mdr",    mem_wdata, 16'h5A5A);
    check("rd_addr",   mem_addr,  exp_mar);
    tick();
    check("rd_done_off", done, 0);
    check("rd_busy_off", busy, 0);

    // Write with no ready: timeout
    bus_in = 16'h00FF; ld_mdr = 1; tick(); ld_mdr = 0;
    wr_start = 1; tick(); wr_start = 0;
    n = 0;
    while (mem_wr && n < 40) begin
      check("to_no_done", done, 0);
      n++;
      tick();
    end
    check("to_wr_cycles", n, TIMEOUT);
    check("to_err",   err,       1);
    check("to_done",  done,      0);
    check("to_busy",  busy,      0);
    check("to_mdr",   mem_wdata, 16'h00FF);
    check("to_addr",  mem_addr,  exp_mar);
    tick();
    check("to_err_off", err, 0);

    // Ready on the cycle the counter would expire: ready wins
    wr_start = 1; tick(); wr_start = 0;
    repeat (TIMEOUT - 1) tick();
    check("lim_wr", mem_wr, 1);
    mem_ready = 1; tick(); mem_ready = 0;
    inc_mar_on_success();
    check("lim_done", done, 1);
    check("lim_err",  err,  0);
    check("lim_addr", mem_addr, exp_mar);
    tick();
    check("lim_err_after", err, 0);
    check("lim_busy_off",  busy, 0);

    // Start conflict
    rd_start = 1; wr_start = 1; tick(); rd_start = 0; wr_start = 0;
    check("cf_err",  err,    1);
    check("cf_rd",   mem_rd, 0);
    check("cf_wr",   mem_wr, 0);
    check("cf_busy", busy,   0);
    tick();
    check("cf_err_off", err, 0);

    // Minimum-latency write with load at the start edge; wraps MAR when auto-increment is on
    bus_in = 16'hFFFF; ld_mar = 1; wr_start = 1; tick(); ld_mar = 0; wr_start = 0;
    exp_mar = 16'hFFFF;
    check("ml_wr",   mem_wr,   1);
    check("ml_addr", mem_addr, 16'hFFFF);
    mem_ready = 1; tick(); mem_ready = 0;
    inc_mar_on_success();
    check("ml_done", done, 1);
    check("ml_addr_after", mem_addr, exp_mar);
    tick();
    check("ml_busy_off", busy, 0);
    check("ml_done_off", done, 0);

    // Reset in the middle of a read
    rd_start = 1; tick(); rd_start = 0;
    check("mr_rd", mem_rd, 1);
    tick();
    rst = 1; tick(); rst = 0;
    check("mr_rd_off", mem_rd,    0);
    check("mr_busy",   busy,      0);
    check("mr_done",   done,      0);
    check("mr_err",    err,       0);
    check("mr_addr",   mem_addr,  0);
    check("mr_mdr",    mem_wdata, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
